// File: rtl/rps_pkg.sv
// Shared types and helpers for the best-of-N rock-paper-scissors match.
// Choice, outcome and FSM encodings plus the LFSR tap mask.
package rps_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } choice_t;

  typedef enum logic [1:0] {
    WIN,
    LOSE,
    TIE
  } outcome_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CHOICE,
    REVEAL,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic beats(choice_t a, choice_t b);
    return (a == ROCK     && b == SCISSORS) ||
           (a == SCISSORS && b == PAPER)    ||
           (a == PAPER    && b == ROCK);
  endfunction

endpackage

// File: rtl/rps_lfsr.sv
// Free-running right-shift Galois LFSR used as the computer's dice.
// Steps every cycle from reset; the seed must be non-zero.
module rps_lfsr
  import rps_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hACE1)
) (
  input  logic             clock,
  input  logic             reset_button,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) state <= SEED;
    else              state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match controller: edge-detects buttons,
// draws the computer's choice from an LFSR and scores each round.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W = 4,
  parameter int REVEAL_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset_button,
  input  logic               rock_button,
  input  logic               paper_button,
  input  logic               scissors_button,
  input  logic               start_button,
  output logic [1:0]         player_choice,
  output logic [1:0]         computer_choice,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] computer_score,
  output logic               win_led,
  output logic               lose_led,
  output logic               tie_led,
  output logic               match_over,
  output logic               match_won
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] REV_LAST = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SCORE_W-1:0] WIN_CNT = SCORE_W'(ROUNDS_TO_WIN);

  state_t           fsm;
  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic [3:0]       btn;
  logic [3:0]       btn_q;
  logic [3:0]       press;
  logic [2:0]       sel;
  logic             choice_ok;
  logic             timeout;
  logic [CNT_W-1:0] cnt;
  choice_t          pick;
  choice_t          draw;
  outcome_t         res;

  rps_lfsr #(
    .WIDTH(16),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock       (clock),
    .reset_button(reset_button),
    .state       (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];

  assign btn   = {start_button, scissors_button, paper_button, rock_button};
  assign press = btn & ~btn_q;

  // One fresh press and nothing else held; chords are ignored.
  assign choice_ok = $onehot(press[2:0]) && (btn[2:0] == press[2:0]);
  assign sel       = press[2:0] & {3{choice_ok}};
  assign timeout   = (TIMEOUT_CYCLES > 0) && (cnt == TMO_LAST);

  always_comb begin
    pick = NONE;
    unique case (1'b1)
      sel[0]:  pick = ROCK;
      sel[1]:  pick = PAPER;
      sel[2]:  pick = SCISSORS;
      default: pick = NONE;
    endcase
  end

  always_comb begin
    draw = choice_t'(lfsr[1:0]);
    if (draw == NONE) draw = choice_t'(lfsr[3:2]);
    if (draw == NONE) draw = ROCK;
  end

  always_comb begin
    res = LOSE;
    if (choice_ok) begin
      if (pick == draw)        res = TIE;
      else if (beats(pick, draw)) res = WIN;
      else                     res = LOSE;
    end
  end

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      fsm             <= IDLE;
      btn_q           <= '0;
      cnt             <= '0;
      player_choice   <= NONE;
      computer_choice <= NONE;
      player_score    <= '0;
      computer_score  <= '0;
      win_led         <= 1'b0;
      lose_led        <= 1'b0;
      tie_led         <= 1'b0;
      match_over      <= 1'b0;
      match_won       <= 1'b0;
    end else begin
      btn_q <= btn;
      unique case (fsm)
        IDLE: begin
          if (press[3]) begin
            player_score   <= '0;
            computer_score <= '0;
            cnt            <= '0;
            fsm            <= WAIT_CHOICE;
          end
        end
        WAIT_CHOICE: begin
          if (choice_ok || timeout) begin
            player_choice   <= pick;
            computer_choice <= draw;
            win_led         <= (res == WIN);
            lose_led        <= (res == LOSE);
            tie_led         <= (res == TIE);
            if (res == WIN && player_score < WIN_CNT)
              player_score <= player_score + SCORE_W'(1);
            if (res == LOSE && computer_score < WIN_CNT)
              computer_score <= computer_score + SCORE_W'(1);
            cnt <= '0;
            fsm <= REVEAL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REVEAL: begin
          if (cnt == REV_LAST) begin
            cnt     <= '0;
            tie_led <= 1'b0;
            if (player_score == WIN_CNT || computer_score == WIN_CNT) begin
              match_over <= 1'b1;
              match_won  <= (player_score == WIN_CNT);
              win_led    <= (player_score == WIN_CNT);
              lose_led   <= (player_score != WIN_CNT);
              fsm        <= DONE;
            end else begin
              win_led  <= 1'b0;
              lose_led <= 1'b0;
              fsm      <= WAIT_CHOICE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (press[3]) begin
            player_choice   <= NONE;
            computer_choice <= NONE;
            player_score    <= '0;
            computer_score  <= '0;
            win_led         <= 1'b0;
            lose_led        <= 1'b0;
            tie_led         <= 1'b0;
            match_over      <= 1'b0;
            match_won       <= 1'b0;
            cnt             <= '0;
            fsm             <= WAIT_CHOICE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
